// File: rtl/pwm_level_ctrl.sv
// Button-stepped brightness level select plus four fixed-duty PWM waveforms.
module pwm_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PWM_PERIOD      = 100,
  parameter int unsigned CNT_W           = 17
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_btn,
  input  logic       i_clr,
  output logic [4:0] o_pwm,
  output logic [2:0] o_sel,
  output logic       o_pwm_wrap
);

  localparam int unsigned PCNT_W = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
  localparam int unsigned QTR    = PWM_PERIOD / 4;

  typedef enum logic [2:0] {
    OFF = 3'd0,
    L1  = 3'd1,
    L2  = 3'd2,
    L3  = 3'd3,
    L4  = 3'd4
  } level_t;

  logic             s1, s2;
  logic [CNT_W-1:0] dcnt;
  logic             btn_db, btn_db_d;
  logic [1:0]       sync_vld;
  logic             armed;
  logic             step_q;
  level_t           state_q, state_d;

  logic [PCNT_W-1:0] pcnt, pcnt_next;
  logic [3:0]        pwm_next;

  // Two-flop synchroniser for the asynchronous button
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  // Debounce: accept a new level only after it has been stable for DEBOUNCE_CYCLES
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dcnt   <= '0;
      btn_db <= 1'b0;
    end else if (s2 == btn_db) begin
      dcnt <= '0;
    end else if (dcnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= s2;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + CNT_W'(1);
    end
  end

  // Rising-edge detect; a press held across reset is ignored until the button is seen low
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      btn_db_d <= 1'b0;
      sync_vld <= 2'b00;
      armed    <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      btn_db_d <= btn_db;
      sync_vld <= {sync_vld[0], 1'b1};
      armed    <= armed | (sync_vld[1] & ~s2);
      step_q   <= btn_db & ~btn_db_d & armed;
    end
  end

  // Level state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Level next-state: clear wins over step
  always_comb begin
    state_d = state_q;
    if (i_clr) begin
      state_d = OFF;
    end else if (step_q) begin
      unique case (state_q)
        OFF:     state_d = L1;
        L1:      state_d = L2;
        L2:      state_d = L3;
        L3:      state_d = L4;
        L4:      state_d = OFF;
        default: state_d = OFF;
      endcase
    end
  end

  assign o_sel = state_q;

  // PWM counter next value and per-duty compare
  always_comb begin
    pcnt_next = (pcnt == PCNT_W'(PWM_PERIOD - 1)) ? '0 : pcnt + PCNT_W'(1);
    pwm_next  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      pwm_next[k] = (32'(pcnt_next) < (k + 1) * QTR);
    end
  end

  // Free-running PWM counter and registered waveforms
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pcnt       <= '0;
      o_pwm      <= '0;
      o_pwm_wrap <= 1'b0;
    end else begin
      pcnt       <= pcnt_next;
      o_pwm      <= {1'b0, pwm_next};
      o_pwm_wrap <= (pcnt_next == '0);
    end
  end

endmodule

// File: tb/tb_pwm_level_ctrl.sv
// Bench for pwm_level_ctrl with a window-based behavioural reference model.
module tb_pwm_level_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned P  = 8;
  localparam int unsigned Q  = P / 4;
  localparam int          DI = 4;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_btn;
  logic       i_clr;
  logic [4:0] o_pwm;
  logic [2:0] o_sel;
  logic       o_pwm_wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        btn;
    logic        clr;
    int unsigned cycles;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t tbl[11];

  pwm_level_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .PWM_PERIOD     (P),
    .CNT_W          (3)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn),
    .i_clr     (i_clr),
    .o_pwm     (o_pwm),
    .o_sel     (o_sel),
    .o_pwm_wrap(o_pwm_wrap)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state: raw-sample history since reset and derived level
  int unsigned m_n;
  bit          m_hist[$];
  bit          m_db, m_rise, m_armed, m_step;
  int unsigned m_sel;

  function automatic bit samp(input int k);
    if (k >= 1 && k <= m_hist.size()) return m_hist[k-1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_hist.delete();
    m_db = 0; m_rise = 0; m_armed = 0; m_step = 0; m_sel = 0;
  endtask

  // Level accepted once the last D synchronised samples all differ from it
  task automatic model_edge(input bit b, input bit c);
    int          e;
    bit          stable, new_db, new_step;
    int unsigned new_sel;
    m_n++;
    e = int'(m_n);
    m_hist.push_back(b);
    new_sel  = c ? 0 : (m_step ? (m_sel + 1) % 5 : m_sel);
    new_step = m_rise & m_armed;
    stable = 1'b1;
    for (int k = e - 1 - DI; k <= e - 2; k++) if (samp(k) == m_db) stable = 1'b0;
    new_db  = stable ? !m_db : m_db;
    m_rise  = new_db & !m_db;
    m_db    = new_db;
    m_armed = m_armed | (e >= 3 && samp(e - 2) == 1'b0);
    m_step  = new_step;
    m_sel   = new_sel;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [4:0]  epwm;
    logic        ewrap;
    int unsigned ph;
    epwm  = '0;
    ewrap = 1'b0;
    if (m_n != 0) begin
      ph = m_n % P;
      for (int unsigned k = 0; k < 4; k++) epwm[k] = (ph < (k + 1) * Q);
      ewrap = (ph == 0);
    end
    chk($sformatf("model_sel@%0d", m_n), 32'(o_sel), 32'(m_sel));
    chk($sformatf("model_pwm@%0d", m_n), 32'(o_pwm), 32'(epwm));
    chk($sformatf("model_wrap@%0d", m_n), 32'(o_pwm_wrap), 32'(ewrap));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic cyc(input logic b, input logic c);
    i_btn = b;
    i_clr = c;
    @(posedge i_clk);
    model_edge(b, c);
    @(negedge i_clk);
    compare_model();
  endtask

  task automatic press();
    repeat (10) cyc(1'b1, 1'b0);
    repeat (8)  cyc(1'b0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi[5];
    int wraps;
    logic b;
    int unsigned len;

    tbl[0]  = '{1'b0, 1'b0, 8,  3'd1};
    tbl[1]  = '{1'b1, 1'b0, 10, 3'd2};
    tbl[2]  = '{1'b0, 1'b0, 8,  3'd2};
    tbl[3]  = '{1'b1, 1'b0, 10, 3'd3};
    tbl[4]  = '{1'b0, 1'b0, 8,  3'd3};
    tbl[5]  = '{1'b1, 1'b0, 10, 3'd4};
    tbl[6]  = '{1'b0, 1'b0, 8,  3'd4};
    tbl[7]  = '{1'b1, 1'b0, 10, 3'd0};
    tbl[8]  = '{1'b0, 1'b0, 8,  3'd0};
    tbl[9]  = '{1'b1, 1'b0, 10, 3'd1};
    tbl[10] = '{1'b0, 1'b0, 8,  3'd1};

    i_reset_n = 1'b0;
    i_btn     = 1'b0;
    i_clr     = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    chk("reset_sel", 32'(o_sel), 32'd0);
    chk("reset_pwm", 32'(o_pwm), 32'd0);
    chk("reset_wrap", 32'(o_pwm_wrap), 32'd0);
    i_reset_n = 1'b1;

    // Free-running PWM duty over three full periods
    for (int k = 0; k < 5; k++) hi[k] = 0;
    wraps = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b0);
      for (int k = 0; k < 5; k++) hi[k] += int'(o_pwm[k]);
      wraps += int'(o_pwm_wrap);
    end
    chk("duty25", 32'(hi[0]), 32'd6);
    chk("duty50", 32'(hi[1]), 32'd12);
    chk("duty75", 32'(hi[2]), 32'd18);
    chk("duty100", 32'(hi[3]), 32'd24);
    chk("pwm4_zero", 32'(hi[4]), 32'd0);
    chk("wrap_count", 32'(wraps), 32'd3);

    // Clean press: level changes exactly seven edges after first sample
    repeat (7) cyc(1'b1, 1'b0);
    chk("latency_before", 32'(o_sel), 32'd0);
    cyc(1'b1, 1'b0);
    chk("latency_step", 32'(o_sel), 32'd1);
    repeat (12) cyc(1'b1, 1'b0);
    chk("held_no_restep", 32'(o_sel), 32'd1);

    // Press/release table including the L4->OFF wrap
    for (int i = 0; i < 11; i++) begin
      repeat (tbl[i].cycles) cyc(tbl[i].btn, tbl[i].clr);
      chk($sformatf("tbl%0d_sel", i), 32'(o_sel), 32'(tbl[i].exp_sel));
    end

    // Short glitch is rejected
    repeat (3) cyc(1'b1, 1'b0);
    repeat (8) cyc(1'b0, 1'b0);
    chk("glitch_reject", 32'(o_sel), 32'd1);

    // Dropouts inside a long press count once
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    chk("dropout_pending", 32'(o_sel), 32'd1);
    repeat (12) cyc(1'b1, 1'b0);
    chk("dropout_once", 32'(o_sel), 32'd2);
    repeat (8) cyc(1'b0, 1'b0);
    chk("dropout_release", 32'(o_sel), 32'd2);

    // Clear coincident with step at level 2
    repeat (7) cyc(1'b1, 1'b0);
    chk("clr_pre", 32'(o_sel), 32'd2);
    cyc(1'b1, 1'b1);
    chk("clr_beats_step", 32'(o_sel), 32'd0);
    repeat (5) cyc(1'b1, 1'b0);
    chk("clr_step_consumed", 32'(o_sel), 32'd0);
    repeat (8) cyc(1'b0, 1'b0);
    repeat (4) press();
    chk("reach_l4", 32'(o_sel), 32'd4);
    cyc(1'b0, 1'b1);
    chk("clr_from_l4", 32'(o_sel), 32'd0);

    // Reset in mid-debounce with the button held
    press();
    chk("pre_reset_sel", 32'(o_sel), 32'd1);
    repeat (4) cyc(1'b1, 1'b0);
    i_reset_n = 1'b0;
    #1;
    chk("async_reset_sel", 32'(o_sel), 32'd0);
    chk("async_reset_pwm", 32'(o_pwm), 32'd0);
    chk("async_reset_wrap", 32'(o_pwm_wrap), 32'd0);
    model_reset();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (20) cyc(1'b1, 1'b0);
    chk("held_through_reset", 32'(o_sel), 32'd0);
    repeat (8) cyc(1'b0, 1'b0);
    press();
    chk("repress_after_reset", 32'(o_sel), 32'd1);

    // Randomised button runs and sparse clears against the model
    for (int i = 0; i < 150; i++) begin
      b   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int unsigned j = 0; j < len; j++) cyc(b, logic'($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
